// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch->decode queue: entry layout and constants.
// The optional same-cycle bypass in fetch_queue is enabled by FETCH_QUEUE_BYPASS_EN.
package fetch_queue_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int FQ_XLEN  = 32;

    localparam logic [FQ_XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] pc_plus_4;
        logic [FQ_XLEN-1:0] instr;
        logic               predict_taken;
        logic               btb_valid;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH x fq_entry_t storage: synchronous write, asynchronous read.
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fq_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output fq_entry_t     rdata
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// First-word-fall-through queue between fetch and decode with flush on redirect.
// Define FETCH_QUEUE_BYPASS_EN to let an entry reach decode in its push cycle when empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = FQ_XLEN
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Flush,
    input  logic                     Push_F,
    input  logic [XLEN-1:0]          PC_F,
    input  logic [XLEN-1:0]          PC_Plus_4_F,
    input  logic [XLEN-1:0]          Instr_F,
    input  logic                     Predict_Taken_F,
    input  logic                     BTB_Valid_F,
    output logic                     Ready_F,
    input  logic                     Stall_D,
    output logic                     Valid_D,
    output logic [XLEN-1:0]          PC_D,
    output logic [XLEN-1:0]          PC_Plus_4_D,
    output logic [XLEN-1:0]          Instr_D,
    output logic                     Predict_Taken_D,
    output logic                     BTB_Valid_D,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    fq_entry_t in_entry, head_entry, out_entry;
    logic      not_empty, push_acc, push_wr, pop, bypass, out_valid;

    always_comb begin
        in_entry.pc            = PC_F;
        in_entry.pc_plus_4     = PC_Plus_4_F;
        in_entry.instr         = Instr_F;
        in_entry.predict_taken = Predict_Taken_F;
        in_entry.btb_valid     = BTB_Valid_F;
    end

    assign not_empty = (count_q != '0);
    assign Ready_F   = (count_q != CW'(DEPTH));
    assign push_acc  = Push_F && Ready_F && !Flush;
    assign pop       = not_empty && !Stall_D && !Flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = !not_empty && Push_F && !Flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry that decode takes immediately never touches storage.
    assign push_wr = push_acc && !(bypass && !Stall_D);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_wr && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push_wr) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (CLK),
        .we    (push_wr),
        .waddr (wr_ptr_q),
        .wdata (in_entry),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    always_comb begin
        out_valid = not_empty || bypass;
        out_entry = bypass ? in_entry : head_entry;
        if (!out_valid) begin
            out_entry               = '0;
            out_entry.instr         = NOP_INSTR;
        end
    end

    assign Valid_D         = out_valid;
    assign PC_D            = out_entry.pc;
    assign PC_Plus_4_D     = out_entry.pc_plus_4;
    assign Instr_D         = out_entry.instr;
    assign Predict_Taken_D = out_entry.predict_taken;
    assign BTB_Valid_D     = out_entry.btb_valid;
    assign Count           = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; expectations are hand-derived per test step.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST, Flush, Push_F, Predict_Taken_F, BTB_Valid_F, Stall_D;
    logic [31:0] PC_F, PC_Plus_4_F, Instr_F;
    logic        Ready_F, Valid_D, Predict_Taken_D, BTB_Valid_D;
    logic [31:0] PC_D, PC_Plus_4_D, Instr_D;
    logic [2:0]  Count;

    int n_chk = 0;
    int n_bad = 0;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam int STREAM_CNT = 0;
`else
    localparam int STREAM_CNT = 1;
`endif

    fetch_queue dut (
        .CLK(CLK), .RST(RST), .Flush(Flush), .Push_F(Push_F),
        .PC_F(PC_F), .PC_Plus_4_F(PC_Plus_4_F), .Instr_F(Instr_F),
        .Predict_Taken_F(Predict_Taken_F), .BTB_Valid_F(BTB_Valid_F),
        .Ready_F(Ready_F), .Stall_D(Stall_D), .Valid_D(Valid_D),
        .PC_D(PC_D), .PC_Plus_4_D(PC_Plus_4_D), .Instr_D(Instr_D),
        .Predict_Taken_D(Predict_Taken_D), .BTB_Valid_D(BTB_Valid_D),
        .Count(Count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
        Push_F      = 1'b1;
        PC_F        = pc;
        PC_Plus_4_F = pc + 32'd4;
        Instr_F     = ins;
    endtask

    initial begin
        RST = 1'b1; Flush = 1'b0; Push_F = 1'b0; Stall_D = 1'b0;
        PC_F = '0; PC_Plus_4_F = '0; Instr_F = '0;
        Predict_Taken_F = 1'b0; BTB_Valid_F = 1'b0;
        step(); step();
        RST = 1'b0;
        step();

        // reset state
        chk("rst_valid", 32'(Valid_D), 32'd0);
        chk("rst_instr", Instr_D, 32'h00000013);
        chk("rst_ready", 32'(Ready_F), 32'd1);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_pc", PC_D, 32'd0);
        chk("rst_pc4", PC_Plus_4_D, 32'd0);
        chk("rst_flags", {30'd0, Predict_Taken_D, BTB_Valid_D}, 32'd0);

        // fill under stall, overflow attempt, then drain in order
        Stall_D = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(32'(4*i), 32'h1000 + 32'(i));
            step();
        end
        chk("full_count", 32'(Count), 32'd4);
        chk("full_ready", 32'(Ready_F), 32'd0);
        offer(32'h10, 32'h2000);
        step();
        chk("ovf_count", 32'(Count), 32'd4);
        chk("ovf_head", PC_D, 32'h0);
        Push_F = 1'b0; Stall_D = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", PC_D, 32'(4*i));
            chk("drain_pc4", PC_Plus_4_D, 32'(4*i + 4));
            chk("drain_instr", Instr_D, 32'h1000 + 32'(i));
            chk("drain_valid", 32'(Valid_D), 32'd1);
            step();
        end
        chk("drain_empty", 32'(Valid_D), 32'd0);
        chk("drain_nop", Instr_D, 32'h00000013);
        chk("drain_count", 32'(Count), 32'd0);

        // streaming push+pop every cycle across pointer wrap
        for (int i = 0; i < 8; i++) begin
            offer(32'(4*i), 32'h3000 + 32'(i));
            step();
            chk("stream_count", 32'(Count), 32'(STREAM_CNT));
            chk("stream_pc", PC_D, 32'(4*i));
            chk("stream_instr", Instr_D, 32'h3000 + 32'(i));
        end
        Push_F = 1'b0;
        step();
        chk("stream_end_cnt", 32'(Count), 32'd0);
        chk("stream_end_vld", 32'(Valid_D), 32'd0);

        // flush with a simultaneous push
        Stall_D = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(32'h30 + 32'(4*i), 32'h4000 + 32'(i));
            step();
        end
        chk("pre_flush_cnt", 32'(Count), 32'd3);
        Flush = 1'b1;
        offer(32'h40, 32'h4444);
        step();
        Flush = 1'b0; Push_F = 1'b0;
        #1;
        chk("flush_count", 32'(Count), 32'd0);
        chk("flush_valid", 32'(Valid_D), 32'd0);
        chk("flush_ready", 32'(Ready_F), 32'd1);
        offer(32'h80, 32'h8888);
        #1;
`ifndef FETCH_QUEUE_BYPASS_EN
        chk("lat_pre_valid", 32'(Valid_D), 32'd0);
`endif
        step();
        Push_F = 1'b0;
        #1;
        chk("post_flush_vld", 32'(Valid_D), 32'd1);
        chk("post_flush_pc", PC_D, 32'h80);
        chk("post_flush_cnt", 32'(Count), 32'd1);
        Stall_D = 1'b0;
        step();
        chk("post_flush_pop", 32'(Count), 32'd0);

        // prediction flags travel with the entry and clear when empty
        Stall_D = 1'b1;
        offer(32'h20, 32'h5555);
        Predict_Taken_F = 1'b1; BTB_Valid_F = 1'b1;
        step();
        Push_F = 1'b0; Predict_Taken_F = 1'b0; BTB_Valid_F = 1'b0;
        #1;
        chk("flag_pc", PC_D, 32'h20);
        chk("flag_pt", 32'(Predict_Taken_D), 32'd1);
        chk("flag_btb", 32'(BTB_Valid_D), 32'd1);
        Stall_D = 1'b0;
        step();
        chk("flag_clr", {30'd0, Predict_Taken_D, BTB_Valid_D}, 32'd0);
        chk("flag_cnt", 32'(Count), 32'd0);

        // pop attempts on empty must not underflow
        step(); step();
        chk("uflow_count", 32'(Count), 32'd0);
        chk("uflow_ready", 32'(Ready_F), 32'd1);
        chk("uflow_instr", Instr_D, 32'h00000013);

        // reset in the middle of activity
        Stall_D = 1'b1;
        offer(32'h200, 32'h6000); step();
        offer(32'h204, 32'h6001); step();
        chk("mid_cnt", 32'(Count), 32'd2);
        RST = 1'b1; Flush = 1'b1; offer(32'h208, 32'h6002);
        step();
        RST = 1'b0; Flush = 1'b0; Push_F = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(Count), 32'd0);
        chk("mid_rst_vld", 32'(Valid_D), 32'd0);
        chk("mid_rst_pc", PC_D, 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        Stall_D = 1'b0;
        offer(32'h100, 32'h7777);
        #1;
        chk("byp_valid", 32'(Valid_D), 32'd1);
        chk("byp_pc", PC_D, 32'h100);
        step();
        Push_F = 1'b0;
        #1;
        chk("byp_count", 32'(Count), 32'd0);
        chk("byp_empty", 32'(Valid_D), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Small first-word-fall-through FIFO between the fetch stage and decode. It decouples PC advance from decode stalls.
- Each entry captures one fetched instruction with its PC, PC+4 and the two BTB/predictor prediction flags.
- Ready_F drives the PC enable. Flush discards all wrong-path entries on an execute-stage redirect.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
XLEN, 32, address/instruction width

Ports:
CLK  input  1  clock, all state updates on posedge
RST  input  1  synchronous, active-high reset
Flush  input  1  redirect from execute (mispredict / taken branch); empties the queue
Push_F  input  1  fetch offers an entry this cycle
PC_F  input  XLEN  PC of offered instruction
PC_Plus_4_F  input  XLEN  PC+4 of offered instruction
Instr_F  input  XLEN  instruction word
Predict_Taken_F  input  1  predictor said taken
BTB_Valid_F  input  1  BTB hit for this PC
Ready_F  output  1  queue accepts a push this cycle; feeds PC_En
Stall_D  input  1  decode cannot consume this cycle
Valid_D  output  1  head entry valid
PC_D  output  XLEN  head PC
PC_Plus_4_D  output  XLEN  head PC+4
Instr_D  output  XLEN  head instruction; NOP (32'h00000013) when !Valid_D
Predict_Taken_D  output  1  head prediction; 0 when !Valid_D
BTB_Valid_D  output  1  head BTB hit; 0 when !Valid_D
Count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (RST=1 at posedge):
  - Write/read pointers and Count go to 0.
  - Next cycle: Ready_F=1, Valid_D=0, Instr_D=NOP, PC_D=PC_Plus_4_D=0, flags=0.
  - Storage contents are don't-care.
- Push accepted = Push_F && Ready_F && !Flush.
- Pop = Valid_D && !Stall_D && !Flush.
- Ready_F = (Count != DEPTH). No same-cycle push-through when full: a pop does not free a slot until the next cycle.
- Valid_D = (Count != 0). Head outputs are an asynchronous read of entry[rd_ptr].
- Latency: an entry pushed at edge N is visible at the output after edge N (1 cycle), even when empty.
- Pointers:
  - log2(DEPTH) bits each; wrap naturally at DEPTH-1 -> 0.
  - wr_ptr increments on accepted push; rd_ptr increments on pop.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Both: unchanged.
  - Neither: unchanged.
- Flush:
  - Highest priority after RST.
  - At the edge: pointers and Count go to 0.
  - Any push or pop offered in the flush cycle is discarded.
  - Outputs show empty on the next cycle.
- Empty with Stall_D=0: no pop, no underflow, outputs hold NOP/0.
- Full with Push_F=1: entry not written, and fetch holds its PC because Ready_F=0.
- RST during any activity: same as the reset rule, regardless of Flush/Push/Stall.
- Count never exceeds DEPTH and never goes below 0 under any input combination.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined:
  - When Count==0, Push_F=1 and Flush=0, the offered entry drives the D outputs combinationally in the same cycle, with Valid_D=1.
  - If Stall_D=0 as well, the entry is consumed directly: not written, pointers/Count unchanged.
  - If Stall_D=1, it is written normally.
  - Empty-queue latency becomes 0 cycles.
- Undefined: 1-cycle latency as above.
- Ready_F behaviour is identical in both builds.

Decomposition:
- Shared package (definitions):
  - typedef struct packed fq_entry_t {pc, pc_plus_4, instr, predict_taken, btb_valid}.
  - Constant NOP_INSTR = 32'h00000013.
  - Constant FQ_DEPTH default.
- One sub-module: fetch_queue_ram, a DEPTH x fq_entry_t array with synchronous write and asynchronous read (distributed RAM).
- Pointer/count control stays in fetch_queue.

Test Plan:
- Reset then idle -> Valid_D=0, Instr_D=32'h00000013, Ready_F=1, Count=0.
- Push PC_F=0x0,0x4,0x8,0xC on 4 consecutive cycles with Stall_D=1 -> Count=4, Ready_F=0; fifth push of 0x10 is ignored. Release the stall -> D outputs show PC 0x0,0x4,0x8,0xC in order, then Valid_D=0.
- Push every cycle with Stall_D=0 for 8 cycles (PC 0x0..0x1C) -> Count stays 1 after the first edge; PCs emerge in order across pointer wrap; no entry lost.
- Count=3, Flush=1 together with Push_F=1 (PC 0x40) -> next cycle Count=0, Valid_D=0. A push of 0x80 on the following cycle appears as the head one cycle later.
- Push 0x20 with Predict_Taken_F=1, BTB_Valid_F=1 -> Predict_Taken_D=1, BTB_Valid_D=1 at head. Pop it -> flags return to 0 when empty.
- With FETCH_QUEUE_BYPASS_EN, empty, push 0x100, Stall_D=0 -> Valid_D=1, PC_D=0x100 in the same cycle, Count remains 0.
